// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer: state encoding and default sizing.
package mac_sequencer_pkg;

  localparam int ADDR_W_DEF   = 4;
  localparam int PIPE_LAT_DEF = 2;
  localparam int STATE_W      = 3;

  // Fixed encoding; downstream checkers decode STATE_DBG_OUT with these values.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // BUSY covers every state that belongs to a job except the DONE pulse.
  function automatic logic is_busy(input state_e s);
    return (s == ST_CLEAR) || (s == ST_ISSUE) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/mac_sequencer_delay_line.sv
// PIPE_LAT-deep 1-bit shift register with enable and synchronous active-low
// clear; tracks operand-valid through the multiplier pipeline.
module mac_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  // Shift one stage per enabled cycle; hold otherwise.
  generate
    if (DEPTH == 1) begin : g_one
      always_comb begin
        sr_d = sr_q;
        if (en) sr_d = din;
      end
    end else begin : g_many
      always_comb begin
        sr_d = sr_q;
        if (en) sr_d = {sr_q[DEPTH-2:0], din};
      end
    end
  endgenerate

  // Register the shift chain; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product job sequencer: clears the accumulator, issues operand addresses
// 0..N-1, aligns accumulate-enable with the multiplier latency, pulses DONE.
//
// Control protocol: START_IN is a request sampled only in IDLE and only on a
// run-cycle (RUN_IN=1); there is no ready/ack, a request outside IDLE is simply
// dropped. RUN_IN=0 freezes every register and gates the pulse outputs low.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              CLK,
  input  logic              RESET_IN,
  input  logic              START_IN,
  input  logic              RUN_IN,
  input  logic [ADDR_W:0]   LEN_IN,
  output logic [ADDR_W-1:0] ADDR_OUT,
  output logic              ISSUE_OUT,
  output logic              CLR_OUT,
  output logic              ACC_EN_OUT,
  output logic              STALL_OUT,
  output logic              BUSY_OUT,
  output logic              DONE_OUT,
  output logic [STATE_W-1:0] STATE_DBG_OUT
);

  localparam logic [ADDR_W:0] MAX_LEN    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]      DRAIN_INIT = 4'(PIPE_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        drain_q, drain_d;
  logic              issue_q, issue_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   last_addr;
  logic              acc_pre;

  // Comparing against len-1 (not incrementing past it) keeps N=2^ADDR_W from wrapping.
  assign last_addr = len_q - LEN_ONE;

  // Next-state, address and drain-counter logic; nothing moves on a frozen cycle.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    if (RUN_IN) begin
      unique case (state_q)
        ST_IDLE: begin
          if (START_IN) begin
            len_d   = (LEN_IN > MAX_LEN) ? MAX_LEN : LEN_IN;
            addr_d  = '0;
            state_d = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          addr_d = '0;
          if (len_q == '0) begin
            drain_d = DRAIN_INIT;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if ({1'b0, addr_q} == last_addr) begin
            drain_d = DRAIN_INIT;
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == 4'd0) state_d = ST_DONE;
          else                 drain_d = drain_q - 4'd1;
        end
        ST_DONE: begin
          addr_d  = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output flags are decoded from the next state so they register with it.
  always_comb begin
    issue_d = (state_d == ST_ISSUE);
    clr_d   = (state_d == ST_CLEAR);
    done_d  = (state_d == ST_DONE);
    busy_d  = is_busy(state_d);
  end

  // State and registered outputs; synchronous active-low reset aborts any job.
  always_ff @(posedge CLK) begin
    if (!RESET_IN) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      drain_q <= '0;
      issue_q <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      issue_q <= issue_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The ungated issue flag feeds the delay line, so a frozen issue is not lost.
  mac_delay_line #(
    .DEPTH (PIPE_LAT)
  ) u_delay (
    .clk   (CLK),
    .rst_n (RESET_IN),
    .en    (RUN_IN),
    .din   (issue_q),
    .dout  (acc_pre)
  );

  assign ADDR_OUT      = addr_q;
  assign ISSUE_OUT     = issue_q & RUN_IN;
  assign CLR_OUT       = clr_q & RUN_IN;
  assign ACC_EN_OUT    = acc_pre & RUN_IN;
  assign DONE_OUT      = done_q & RUN_IN;
  assign BUSY_OUT      = busy_q;
  assign STALL_OUT     = busy_q & ~RUN_IN;
  assign STATE_DBG_OUT = state_q;

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Control sequencer for the MAC datapath. Computes one N-element dot product per job: clears the accumulator, walks operand addresses 0..N-1, then times the accumulate-enable to match the multiplier pipeline latency, and signals completion. RUN_IN freezes and resumes a job, with the same semantics as the existing MAC FSM. Sits between the top-level controller and the operand memory plus the MAC datapath.

Parameters:
ADDR_W, 4, operand address width; maximum vector length is 2^ADDR_W.
PIPE_LAT, 2, cycles from operand address issue to product valid at the accumulator input. Legal range is 1 to 8.

Ports:
CLK  in  1  rising-edge clock
RESET_IN  in  1  synchronous, active-low reset; sampled on the CLK rising edge
START_IN  in  1  job request; sampled only in IDLE
RUN_IN  in  1  1 = advance; 0 = freeze all state
LEN_IN  in  ADDR_W+1  vector length N (0..2^ADDR_W); latched on accepted START
ADDR_OUT  out  ADDR_W  operand address to memory
ISSUE_OUT  out  1  ADDR_OUT is a valid read this cycle
CLR_OUT  out  1  clear the accumulator
ACC_EN_OUT  out  1  accumulate the product this cycle
STALL_OUT  out  1  hold the datapath pipeline registers
BUSY_OUT  out  1  job in progress
DONE_OUT  out  1  one-cycle pulse; the accumulator holds the final result

Behaviour:
- Reset (RESET_IN=0 at an edge): state=IDLE. All outputs are 0 from that edge onward, including ADDR_OUT. The delay line and counters clear. Reset mid-job aborts the job; no DONE is issued.
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE. The encoding is fixed in the shared header.
- IDLE: if START_IN=1 and RUN_IN=1, latch LEN_IN into len_q and go to CLEAR. Otherwise stay in IDLE.
- CLEAR (one run-cycle): CLR_OUT=1 and BUSY_OUT=1.
  - If len_q=0, go to DRAIN.
  - Otherwise go to ISSUE with addr=0.
- ISSUE: ISSUE_OUT=1 with ADDR_OUT=addr.
  - addr increments each run-cycle.
  - After issuing addr=len_q-1, go to DRAIN.
  - N=2^ADDR_W is legal: the final address is all-ones, and addr must not wrap into an extra issue.
- Delay line: ISSUE_OUT (pre-gating) enters a PIPE_LAT-deep shift register that advances only on run-cycles. Its output is ACC_EN_OUT, gated with RUN_IN.
  - In run-cycles, ACC_EN_OUT is exactly ISSUE_OUT delayed by PIPE_LAT.
- DRAIN: lasts exactly PIPE_LAT run-cycles (down-counter), then go to DONE.
  - ACC_EN_OUT for the last operand occurs in the final DRAIN cycle.
- DONE: DONE_OUT=1 for one run-cycle with BUSY_OUT=0, then return to IDLE.
  - A new START is accepted in the cycle after DONE, never in DONE itself.
- BUSY_OUT=1 in CLEAR, ISSUE and DRAIN.
- Freeze (RUN_IN=0):
  - State, addr, len_q, the drain counter and the delay line hold.
  - ISSUE_OUT, CLR_OUT, ACC_EN_OUT and DONE_OUT are forced to 0.
  - ADDR_OUT and BUSY_OUT hold their values.
  - STALL_OUT = BUSY_OUT & ~RUN_IN.
  - On resume, the sequence continues with no lost or duplicated issue or accumulate.
- START_IN while not in IDLE is ignored. LEN_IN changes after acceptance are ignored.
- LEN_IN > 2^ADDR_W saturates to 2^ADDR_W.
- Simultaneous RESET_IN=0 and any other input: reset wins.

Decomposition:
- Shared header mac_defs.vh holds:
  - state localparams (IDLE=0, CLEAR=1, ISSUE=2, DRAIN=3, DONE=4), 3-bit state width
  - default ADDR_W and PIPE_LAT
- One sub-module, mac_delay_line: a PIPE_LAT-deep 1-bit shift register with enable and synchronous active-low clear. It is reused by the datapath valid tracking.

Test Plan:
- Basic job: ADDR_W=4, PIPE_LAT=2, LEN=4, START at cycle 0, RUN=1 → CLR@1; ISSUE@2-5 with ADDR 0,1,2,3; ACC_EN@4-7; BUSY@1-7; DONE@8 only; IDLE@9.
- Freeze: same job with RUN=0 during cycles 4-5 → all outputs gated low except BUSY, ADDR_OUT and STALL_OUT. During the freeze BUSY=1, ADDR_OUT holds 2 (the value in effect when RUN fell) and STALL_OUT=1. Issue resumes at addr 2, four ISSUE and four ACC_EN pulses total, DONE@10.
- Zero length: LEN=0 → CLR@1, DRAIN 2 cycles with no ISSUE or ACC_EN, DONE@4.
- Full length: LEN=16 → ISSUE ADDR 0..15 (16 pulses, no wrap to 0), 16 ACC_EN pulses, DONE@20.
- Reset mid-job: RESET_IN=0 at cycle 3 of the basic job → all outputs 0 from cycle 4, no DONE. A START at cycle 5 replays the basic job timing offset by 5.
- Back-to-back and ignored START: START held high continuously with LEN=2. Extra STARTs during BUSY are ignored; the second job's CLR occurs 2 cycles after the first DONE (IDLE sample, then CLEAR). Sweep PIPE_LAT=1 and 8 and check ACC_EN tracks ISSUE by exactly PIPE_LAT.
